sumador_seq: RTL

SUMADOR_SEQ -- requirements
Module: sumador_seq

---
 rtl/sumador_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/sumador_seq.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per clock through a ripple carry
// register; S, carry_out and overflow are registered and change only on completion.
module sumador_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    output logic [WIDTH-1:0] S,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic [CHUNK:0]   chunk_sum;

    always_comb begin
        chunk_a   = a_q[idx_q*CHUNK +: CHUNK];
        chunk_b   = b_q[idx_q*CHUNK +: CHUNK];
        chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};

        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    a_d     = A;
                    // Subtraction is A + ~B + ~borrow, so B and the carry are inverted at latch time
                    b_d     = op ? ~B : B;
                    carry_d = op ? ~carry_in : carry_in;
                    idx_d   = '0;
                end
            end
            BUSY: begin
                acc_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d = chunk_sum[CHUNK];
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(N - 1)) begin
                    state_d = DONE;
                    s_d     = acc_d;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign S         = s_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q == BUSY);
    assign done      = (state_q == DONE);

endmodule
